obstacle_interval_gen: RTL and testbench
========================================

Name: obstacle_interval_gen

Overview:
- Upstream stage of the obstacle down-counter. Generates pseudo-random spawn intervals and issues them as a one-cycle load (load_en plus load_data) into the counter.
- Watches the counter value returned by the counter. When it reaches zero, emits a one-cycle obstacle spawn pulse with a random obstacle type, then reloads the counter.
- A difficulty level input narrows the random range so obstacles arrive more frequently.

Parameters:
- BITS, 9, width of the counter load/value bus.
- MIN_GAP, 64, minimum interval in clocks; must satisfy 1 ≤ MIN_GAP ≤ 2^BITS-1.
- SEED, 16'hACE1, LFSR reset value; must be nonzero.

Ports:
- clk  input  1  clock
- rst_n  input  1  synchronous active-low reset
- enable  input  1  game running; gates the FSM and LFSR advance
- level  input  2  difficulty 0..3, sampled only when load_data is computed
- cnt_value  input  BITS  current value of the downstream down-counter
- load_en  output  1  one-cycle load strobe to the counter
- load_data  output  BITS  interval value to load, registered
- spawn  output  1  one-cycle obstacle spawn pulse
- obstacle_type  output  2  type of the obstacle spawned; valid with spawn, held until the next spawn
- spawn_count  output  8  saturating count of spawns since reset

Behaviour:
- All state updates on the rising edge of clk. Reset is synchronous: rst_n=0 sampled on an edge forces the reset state regardless of the current state.
- Reset values:
  - state=IDLE
  - lfsr=SEED
  - load_en=0, load_data=0, spawn=0
  - obstacle_type=0, spawn_count=0
- LFSR:
  - 16-bit Galois, right-shifting, tap mask 16'hB400.
  - Next value = (lfsr>>1) ^ (lfsr[0] ? 16'hB400 : 0).
  - Advances on every edge where enable=1; holds when enable=0.
  - If the register ever holds 0, the next value is SEED.
- Interval computation:
  - mask = (2^(BITS-1)-1) >> level.
  - sum = MIN_GAP + (lfsr[BITS-1:0] & mask), computed in BITS+1 bits.
  - load_data = sum saturated to 2^BITS-1.
  - Uses the pre-advance lfsr value on the edge that enters LOAD.
- FSM states and registered outputs:
  - IDLE: load_en=0. If enable=1, go to LOAD and register load_data.
  - LOAD: load_en=1 for exactly this cycle, load_data stable. Next state is always ARM; LOAD is never aborted.
  - ARM: load_en=0. One-cycle wait so that cnt_value reflects the loaded value. If enable=0 go to IDLE, else go to COUNT.
  - COUNT:
    - If enable=0, go to IDLE; enable has priority over cnt_value==0, and no spawn is issued.
    - Else if cnt_value==0, go to SPAWN, set spawn=1 on entry, set obstacle_type=lfsr[15:14] (pre-advance value), and increment spawn_count, saturating at 255.
    - Otherwise stay in COUNT.
  - SPAWN: spawn=1 for exactly this cycle. If enable=1, go to LOAD and register a new load_data; else go to IDLE.
- Counter contract: the downstream counter loads load_data on the edge where load_en=1, and decrements once per clk otherwise.
- Period: with load value N, the spawn-to-spawn period is N+3 clocks in steady state.
- load_data holds its last value outside LOAD. load_en and spawn are never high in the same cycle.
- Reset mid-operation (any state) returns to IDLE. spawn_count is cleared on reset. No pending spawn survives a reset.

Test Plan:
- Reset, then enable=1, level=0, defaults: LOAD is entered 1 cycle later. load_en=1 for one cycle with load_data=64+(0x0E1&255)=289. Drive cnt_value from a model counter: spawn fires exactly 291 clocks after the LOAD cycle, which is the LOAD→LOAD distance of N+3 (289+3=292) minus the one post-spawn LOAD cycle. obstacle_type equals the model lfsr[15:14] and spawn_count=1.
- Same stimulus with level=3: first load_data=64+(225&31)=65. Spawn-to-spawn period = next load value+3. All load_data values lie in 64..95 over 50 spawns.
- MIN_GAP=400 override, level=0: first sum=400+225=625, so load_data saturates to 511.
- Drop enable in COUNT on the same cycle cnt_value==0: no spawn pulse, state IDLE, and the LFSR stops advancing. Re-raise enable: LOAD follows 1 cycle later with no spurious spawn.
- Assert rst_n=0 for one edge during SPAWN and during LOAD: all outputs return to reset values on the next cycle, spawn_count=0, and lfsr=SEED.
- Run 300 spawns at level=3: spawn_count saturates at 255 and holds. Every spawn is exactly one cycle wide, and load_en/spawn are never coincident.

Source files
------------

// File: rtl/obstacle_interval_gen.sv
// obstacle_interval_gen: loads LFSR-derived spawn intervals into a down-counter
// and pulses spawn with a random obstacle type each time that counter reaches zero.
`timescale 1ns/1ps
module obstacle_interval_gen #(
    parameter int          BITS    = 9,
    parameter int          MIN_GAP = 64,
    parameter logic [15:0] SEED    = 16'hACE1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            enable,
    input  logic [1:0]      level,
    input  logic [BITS-1:0] cnt_value,
    output logic            load_en,
    output logic [BITS-1:0] load_data,
    output logic            spawn,
    output logic [1:0]      obstacle_type,
    output logic [7:0]      spawn_count
);
    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] LOAD  = 3'd1;
    localparam logic [2:0] ARM   = 3'd2;
    localparam logic [2:0] COUNT = 3'd3;
    localparam logic [2:0] SPAWN = 3'd4;
    localparam logic [BITS-1:0] HALF_MASK = {1'b0, {(BITS-1){1'b1}}};
    localparam logic [BITS:0]   GAP = (BITS+1)'(MIN_GAP);

    logic [2:0]      state_q, state_d;
    logic [15:0]     lfsr_q, lfsr_d;
    logic [BITS-1:0] load_data_q, load_data_d, interval;
    logic [BITS:0]   sum;
    logic            load_en_q, spawn_q;
    logic [1:0]      type_q, type_d;
    logic [7:0]      count_q, count_d;

    // A zero register would lock the LFSR, so it is reseeded instead
    assign lfsr_d = !enable ? lfsr_q :
                    lfsr_q == '0 ? SEED : (lfsr_q >> 1) ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
    assign sum = GAP + {1'b0, lfsr_q[BITS-1:0] & (HALF_MASK >> level)};
    assign interval = sum[BITS] ? '1 : sum[BITS-1:0];

    always_comb begin
        state_d     = state_q;
        load_data_d = load_data_q;
        type_d      = type_q;
        count_d     = count_q;
        case (state_q)
            IDLE:  state_d = enable ? LOAD : IDLE;
            LOAD:  state_d = ARM;
            ARM:   state_d = enable ? COUNT : IDLE;
            COUNT: begin
                if (!enable) begin
                    state_d = IDLE;
                end else if (cnt_value == '0) begin
                    state_d = SPAWN;
                    type_d  = lfsr_q[15:14];
                    count_d = count_q + {7'd0, count_q != 8'hFF};
                end
            end
            SPAWN:   state_d = enable ? LOAD : IDLE;
            default: state_d = IDLE;
        endcase
        if (state_d == LOAD) load_data_d = interval;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            lfsr_q      <= SEED;
            load_data_q <= '0;
            load_en_q   <= 1'b0;
            spawn_q     <= 1'b0;
            type_q      <= 2'd0;
            count_q     <= 8'd0;
        end else begin
            state_q     <= state_d;
            lfsr_q      <= lfsr_d;
            load_data_q <= load_data_d;
            load_en_q   <= state_d == LOAD;
            spawn_q     <= state_d == SPAWN;
            type_q      <= type_d;
            count_q     <= count_d;
        end
    end

    assign load_en       = load_en_q;
    assign load_data     = load_data_q;
    assign spawn         = spawn_q;
    assign obstacle_type = type_q;
    assign spawn_count   = count_q;
endmodule

// File: tb/tb_obstacle_interval_gen.sv
// tb_obstacle_interval_gen: directed bench driving the generator with a model down-counter
`timescale 1ns/1ps
module tb_obstacle_interval_gen;
    localparam logic [15:0] SEED = 16'hACE1;

    logic        clk = 1'b0, rst_n = 1'b0, enable = 1'b0;
    logic [1:0]  level = 2'd0;
    logic [8:0]  cnt_value = 9'd0;
    logic        load_en, spawn;
    logic [8:0]  load_data;
    logic [1:0]  obstacle_type;
    logic [7:0]  spawn_count;
    logic        s_load_en, s_spawn;
    logic [8:0]  s_load_data;
    logic [1:0]  s_type;
    logic [7:0]  s_count;
    logic [15:0] m_lfsr, m_prev;
    int          checks = 0, failures = 0;

    always #5 clk = ~clk;

    obstacle_interval_gen dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .level(level), .cnt_value(cnt_value),
        .load_en(load_en), .load_data(load_data), .spawn(spawn),
        .obstacle_type(obstacle_type), .spawn_count(spawn_count)
    );

    obstacle_interval_gen #(.MIN_GAP(400)) dut_sat (
        .clk(clk), .rst_n(rst_n), .enable(enable), .level(level), .cnt_value(9'd0),
        .load_en(s_load_en), .load_data(s_load_data), .spawn(s_spawn),
        .obstacle_type(s_type), .spawn_count(s_count)
    );

    // Reference LFSR (m_prev is the pre-advance value of the last edge) and downstream counter
    always @(posedge clk) begin
        m_prev <= m_lfsr;
        if (!rst_n) m_lfsr <= SEED;
        else if (enable) m_lfsr <= (m_lfsr == 16'h0) ? SEED :
                                   ((m_lfsr >> 1) ^ (m_lfsr[0] ? 16'hB400 : 16'h0000));
        cnt_value <= !rst_n ? 9'd0 : load_en ? load_data : cnt_value - 9'd1;
    end

    function automatic int exp_load(input logic [15:0] l, input logic [1:0] lv);
        int s;
        s = 64 + int'(l[8:0] & (9'd255 >> lv));
        return s > 511 ? 511 : s;
    endfunction

    task automatic do_reset(input logic [1:0] lv);
        rst_n = 1'b0; enable = 1'b0; level = lv;
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0; enable = 1'b0;
        @(negedge clk); @(negedge clk);
        checks++;
        if ({load_en, spawn, load_data, obstacle_type, spawn_count} !== 21'd0) begin
            failures++;
            $display("FAIL reset_outputs got en=%b sp=%b ld=%0d ty=%0d cnt=%0d want all 0",
                     load_en, spawn, load_data, obstacle_type, spawn_count);
        end
        checks++;
        if (dut.lfsr_q !== SEED) begin
            failures++; $display("FAIL reset_lfsr got %h want %h", dut.lfsr_q, SEED);
        end
    endtask

    task automatic test_basic;
        int n;
        do_reset(2'd0);
        enable = 1'b1;
        @(negedge clk);
        checks++;
        if (load_en !== 1'b1 || load_data !== 9'd289) begin
            failures++; $display("FAIL basic_first_load got en=%b ld=%0d want en=1 ld=289", load_en, load_data);
        end
        checks++;
        if (s_load_en !== 1'b1 || s_load_data !== 9'd511) begin
            failures++; $display("FAIL sat_first_load got en=%b ld=%0d want en=1 ld=511", s_load_en, s_load_data);
        end
        n = 0;
        while (spawn !== 1'b1 && n < 400) begin @(negedge clk); n++; end
        checks++;
        if (n != 291) begin
            failures++; $display("FAIL basic_spawn_delay got %0d want 291", n);
        end
        checks++;
        if (obstacle_type !== m_prev[15:14]) begin
            failures++; $display("FAIL basic_type got %0d want %0d", obstacle_type, m_prev[15:14]);
        end
        checks++;
        if (spawn_count !== 8'd1 || load_en !== 1'b0) begin
            failures++; $display("FAIL basic_count got cnt=%0d en=%b want cnt=1 en=0", spawn_count, load_en);
        end
    endtask

    task automatic test_level3;
        int spawns, cyc, last, ld;
        do_reset(2'd3);
        enable = 1'b1;
        @(negedge clk);
        checks++;
        if (load_data !== 9'd65) begin
            failures++; $display("FAIL l3_first_load got %0d want 65", load_data);
        end
        spawns = 0; cyc = 0; last = -1; ld = 0;
        while (spawns < 50 && cyc < 6000) begin
            if (load_en === 1'b1) begin
                ld = int'(load_data);
                checks++;
                if (ld < 64 || ld > 95 || ld != exp_load(m_prev, 2'd3)) begin
                    failures++; $display("FAIL l3_load_value got %0d want %0d", ld, exp_load(m_prev, 2'd3));
                end
            end
            if (spawn === 1'b1) begin
                if (last >= 0) begin
                    checks++;
                    if (cyc - last != ld + 3) begin
                        failures++; $display("FAIL l3_period got %0d want %0d", cyc - last, ld + 3);
                    end
                end
                last = cyc; spawns++;
            end
            @(negedge clk); cyc++;
        end
        checks++;
        if (spawns != 50) begin
            failures++; $display("FAIL l3_spawns got %0d want 50", spawns);
        end
    endtask

    task automatic test_enable_drop;
        int cyc;
        logic [15:0] l0;
        do_reset(2'd3);
        enable = 1'b1;
        cyc = 0;
        while (load_en !== 1'b1 && cyc < 10) begin @(negedge clk); cyc++; end
        @(negedge clk);
        cyc = 0;
        while (cnt_value !== 9'd0 && cyc < 200) begin @(negedge clk); cyc++; end
        checks++;
        if (cnt_value !== 9'd0 || dut.state_q !== 3'd3) begin
            failures++; $display("FAIL drop_reach_zero got cnt=%0d st=%0d want cnt=0 st=3", cnt_value, dut.state_q);
        end
        enable = 1'b0;
        @(negedge clk);
        checks++;
        if (spawn !== 1'b0 || dut.state_q !== 3'd0) begin
            failures++; $display("FAIL drop_no_spawn got sp=%b st=%0d want sp=0 st=0", spawn, dut.state_q);
        end
        l0 = dut.lfsr_q;
        repeat (5) @(negedge clk);
        checks++;
        if (dut.lfsr_q !== l0 || l0 !== m_lfsr) begin
            failures++; $display("FAIL drop_lfsr_hold got %h want %h", dut.lfsr_q, m_lfsr);
        end
        checks++;
        if (spawn !== 1'b0 || load_en !== 1'b0 || spawn_count !== 8'd0) begin
            failures++; $display("FAIL drop_idle got sp=%b en=%b cnt=%0d want 0 0 0", spawn, load_en, spawn_count);
        end
        enable = 1'b1;
        @(negedge clk);
        checks++;
        if (load_en !== 1'b1 || spawn !== 1'b0 || int'(load_data) != exp_load(m_prev, 2'd3)) begin
            failures++; $display("FAIL drop_reload got en=%b sp=%b ld=%0d want en=1 sp=0 ld=%0d",
                                 load_en, spawn, load_data, exp_load(m_prev, 2'd3));
        end
    endtask

    task automatic test_reset_mid;
        int cyc;
        do_reset(2'd3);
        enable = 1'b1;
        cyc = 0;
        while (spawn !== 1'b1 && cyc < 200) begin @(negedge clk); cyc++; end
        checks++;
        if (spawn !== 1'b1 || spawn_count !== 8'd1) begin
            failures++; $display("FAIL mid_reach_spawn got sp=%b cnt=%0d want 1 1", spawn, spawn_count);
        end
        rst_n = 1'b0;
        @(negedge clk);
        checks++;
        if ({load_en, spawn, load_data, obstacle_type, spawn_count} !== 21'd0 || dut.lfsr_q !== SEED) begin
            failures++; $display("FAIL mid_reset_spawn got en=%b sp=%b ld=%0d ty=%0d cnt=%0d lfsr=%h want zeros lfsr=%h",
                                 load_en, spawn, load_data, obstacle_type, spawn_count, dut.lfsr_q, SEED);
        end
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (load_en !== 1'b1 || load_data !== 9'd65) begin
            failures++; $display("FAIL mid_restart got en=%b ld=%0d want en=1 ld=65", load_en, load_data);
        end
        rst_n = 1'b0;
        @(negedge clk);
        checks++;
        if ({load_en, spawn, load_data, obstacle_type, spawn_count} !== 21'd0 || dut.lfsr_q !== SEED) begin
            failures++; $display("FAIL mid_reset_load got en=%b sp=%b ld=%0d ty=%0d cnt=%0d lfsr=%h want zeros lfsr=%h",
                                 load_en, spawn, load_data, obstacle_type, spawn_count, dut.lfsr_q, SEED);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_saturate;
        int spawns, cyc, e;
        logic prev;
        do_reset(2'd3);
        enable = 1'b1;
        spawns = 0; cyc = 0; prev = 1'b0;
        while (spawns < 300 && cyc < 32000) begin
            @(negedge clk); cyc++;
            if (spawn === 1'b1) begin
                spawns++;
                e = spawns > 255 ? 255 : spawns;
                checks++;
                if (prev !== 1'b0 || load_en !== 1'b0 || spawn_count !== 8'(e)) begin
                    failures++; $display("FAIL sat_spawn%0d got prev=%b en=%b cnt=%0d want 0 0 %0d",
                                         spawns, prev, load_en, spawn_count, e);
                end
            end
            prev = spawn;
        end
        checks++;
        if (spawns != 300) begin
            failures++; $display("FAIL sat_spawns got %0d want 300", spawns);
        end
        repeat (5) @(negedge clk);
        checks++;
        if (spawn_count !== 8'd255) begin
            failures++; $display("FAIL sat_hold got %0d want 255", spawn_count);
        end
    endtask

    initial begin
        test_reset;
        test_basic;
        test_level3;
        test_enable_drop;
        test_reset_mid;
        test_saturate;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
